dump_sm: RTL

Dump state machine for the capture RAM. On a dump request it reads all `DEPTH` stored samples of one channel, oldest first, through the RAM interface's `dump_en` / `ch_sel` / `read_data` path. It hands each byte to the UART transmitter with a start/done handshake. It is the read-side counterpart to the capture state machine and sits between the RAM interface and the UART TX.

---
 rtl/dump_sm_pkg.sv | 8 +
 rtl/dump_sm_if.sv | 22 ++
 rtl/dump_sm_circ_addr_ctr.sv | 19 +
 rtl/dump_sm.sv | 56 +++++
 4 files changed

// File: rtl/dump_sm_pkg.sv
// dump_sm_pkg: shared state and channel codes for the capture RAM dump path
package dump_sm_pkg;
  typedef enum logic [1:0] {IDLE, READ, SEND, WAIT_TX} dump_state_t;
  localparam logic [1:0] CH_NONE = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;
endpackage

// File: rtl/dump_sm_if.sv
// dump_sm_if: request, RAM read and UART TX signals of the dump state machine
interface dump_sm_if #(parameter int AW = 9);
  logic dump_start;
  logic [1:0] dump_chan;
  logic [AW-1:0] trig_pos;
  logic [7:0] read_data;
  logic tx_done;
  logic dump_en;
  logic [1:0] ch_sel;
  logic [AW-1:0] addr;
  logic [7:0] tx_data;
  logic tx_start;
  logic dump_finished;
  modport master(
    input dump_start, dump_chan, trig_pos, read_data, tx_done,
    output dump_en, ch_sel, addr, tx_data, tx_start, dump_finished
  );
  modport slave(
    output dump_start, dump_chan, trig_pos, read_data, tx_done,
    input dump_en, ch_sel, addr, tx_data, tx_start, dump_finished
  );
endinterface

// File: rtl/dump_sm_circ_addr_ctr.sv
// circ_addr_ctr: loadable wrapping address counter, tc flags val == tc_val
module circ_addr_ctr #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  input  logic [AW-1:0] tc_val,
  output logic [AW-1:0] val,
  output logic          tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val <= '0;
    else if (load) val <= load_val;
    else if (inc) val <= val + 1'b1;
  assign tc = val == tc_val;
endmodule

// File: rtl/dump_sm.sv
// dump_sm: reads one channel's circular buffer oldest-first and streams it to the UART
module dump_sm
  import dump_sm_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH),
  parameter int RD_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  dump_sm_if.master bus
);
  localparam int RW = $clog2(RD_LAT + 1);
  dump_state_t state, next;
  logic [RW-1:0] rd_cnt;
  logic [AW-1:0] end_addr;
  logic go, rd_end, done, last;
  assign go = state == IDLE && bus.dump_start && bus.dump_chan != CH_NONE;
  assign rd_end = state == READ && rd_cnt == RW'(RD_LAT - 1);
  assign done = state == WAIT_TX && bus.tx_done;
  // The newest sample (trig_pos) is the last one sent, so it doubles as the byte count limit
  circ_addr_ctr #(.AW(AW)) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .load(go),
    .inc(done && !last),
    .load_val(bus.trig_pos + 1'b1),
    .tc_val(end_addr),
    .val(bus.addr),
    .tc(last)
  );
  always_comb begin
    next = go ? READ : rd_end ? SEND : state == SEND ? WAIT_TX : done ? (last ? IDLE : READ) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt <= '0;
      end_addr <= '0;
      bus.dump_en <= 1'b0;
      bus.ch_sel <= CH_NONE;
      bus.tx_data <= '0;
      bus.tx_start <= 1'b0;
      bus.dump_finished <= 1'b0;
    end else begin
      rd_cnt <= state == READ && !rd_end ? rd_cnt + 1'b1 : '0;
      end_addr <= go ? bus.trig_pos : end_addr;
      bus.dump_en <= next == READ;
      bus.ch_sel <= go ? bus.dump_chan : next == IDLE ? CH_NONE : bus.ch_sel;
      bus.tx_data <= rd_end ? bus.read_data : bus.tx_data;
      bus.tx_start <= next == SEND;
      bus.dump_finished <= done && last;
    end
endmodule
